l2_port_arbiter: RTL and testbench

Shares the single L2 request port between the instruction cache and the data cache.

- Accepts the same request/fulfil handshake from each cache and grants the port to one cache at a time.
- Grants alternate round-robin, and a grant is held until L2 fulfils the request.
- Sits between the two L1 controllers and the L2, and drives the L2 port the way a lone cache would.

---
 rtl/xentry_pkg.sv | 26 ++
 rtl/l2_port_arbiter.sv | 106 ++++++++++
 tb/tb_l2_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xentry_pkg.sv
// Shared types for the xentry memory subsystem: memory operations and the
// L2 port arbiter's state and requester identities.
package xentry_pkg;

    typedef enum logic [1:0] {
        MEM_LOAD              = 2'd0,
        MEM_STORE             = 2'd1,
        MEM_LOAD_RESERVED     = 2'd2,
        MEM_STORE_CONDITIONAL = 2'd3
    } memory_operation_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arbiter_state_e;

    typedef enum logic {
        REQ_ICACHE,
        REQ_DCACHE
    } l2_requester_e;

    function automatic l2_requester_e other_requester(input l2_requester_e r);
        return (r == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
    endfunction

endpackage

// File: rtl/l2_port_arbiter.sv
// Shares one L2 request port between the icache and dcache: round-robin grant,
// held until L2 fulfils, with the L2 fulfil pulse passed straight to the owner.
module l2_port_arbiter
    import xentry_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [XLEN-1:0]   ic_req_address,
    input  memory_operation_e ic_req_type,
    input  logic              ic_req_valid,
    input  logic [XLEN-1:0]   ic_word_to_store,
    output logic [XLEN-1:0]   ic_fetched_word,
    output logic              ic_req_fulfilled,

    input  logic [XLEN-1:0]   dc_req_address,
    input  memory_operation_e dc_req_type,
    input  logic              dc_req_valid,
    input  logic [XLEN-1:0]   dc_word_to_store,
    output logic [XLEN-1:0]   dc_fetched_word,
    output logic              dc_req_fulfilled,

    output logic [XLEN-1:0]   l2_req_address,
    output memory_operation_e l2_req_type,
    output logic              l2_req_valid,
    output logic [XLEN-1:0]   l2_word_to_store,
    input  logic [XLEN-1:0]   l2_fetched_word,
    input  logic              l2_req_fulfilled
);

    arbiter_state_e state;
    l2_requester_e  owner;
    l2_requester_e  last_owner;
    l2_requester_e  grant_pick;
    logic           busy;
    logic           owner_valid;

    assign busy        = (state == ARB_BUSY);
    assign owner_valid = (owner == REQ_DCACHE) ? dc_req_valid : ic_req_valid;

    // On a tie the requester served last yields, which bounds each side's wait
    // to one transaction of the other.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        grant_pick = REQ_ICACHE;
        if (ic_req_valid && dc_req_valid)
            grant_pick = other_requester(last_owner);
        else if (dc_req_valid)
            grant_pick = REQ_DCACHE;
    end

    // NOTE: state registers use non-blocking assignments so every register in
    // the block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner      <= REQ_ICACHE;
            last_owner <= REQ_ICACHE;
        end else if (state == ARB_IDLE) begin
            if (ic_req_valid || dc_req_valid) begin
                owner <= grant_pick;
                state <= ARB_BUSY;
            end
        end else begin
            if (l2_req_fulfilled) begin
                last_owner <= owner;
                state      <= ARB_IDLE;
            end else if (!owner_valid) begin
                // Owner withdrew without fulfilment: drop the grant, keep history.
                state <= ARB_IDLE;
            end
        end
    end

    // The L2 side is gated by the state register, so an async reset clears it at once.
    always_comb begin
        l2_req_valid     = 1'b0;
        l2_req_address   = '0;
        l2_req_type      = memory_operation_e'(0);
        l2_word_to_store = '0;
        if (busy) begin
            if (owner == REQ_DCACHE) begin
                l2_req_valid     = dc_req_valid;
                l2_req_address   = dc_req_address;
                l2_req_type      = dc_req_type;
                l2_word_to_store = dc_word_to_store;
            end else begin
                l2_req_valid     = ic_req_valid;
                l2_req_address   = ic_req_address;
                l2_req_type      = ic_req_type;
                l2_word_to_store = ic_word_to_store;
            end
        end
    end

    assign ic_req_fulfilled = busy && (owner == REQ_ICACHE) && l2_req_fulfilled;
    assign dc_req_fulfilled = busy && (owner == REQ_DCACHE) && l2_req_fulfilled;

    // Read data goes to both caches; each qualifies it with its own fulfilled.
    assign ic_fetched_word = l2_fetched_word;
    assign dc_fetched_word = l2_fetched_word;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed vector table, reset/corner sequences, and
// reactive random traffic scored against a grant-level reference model.
module tb_l2_port_arbiter;
    import xentry_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] IC_ADDR     = 32'h0000_0200;
    localparam logic [31:0] IC_WD       = 32'hCAFE_0001;
    localparam logic [31:0] DC_LD_ADDR  = 32'h0000_1040;
    localparam logic [31:0] DC_LD_WD    = 32'h0BAD_F00D;
    localparam logic [31:0] DC_ST_ADDR  = 32'h0000_2000;
    localparam logic [31:0] DC_ST_WD    = 32'h1234_5678;

    logic              clk;
    logic              reset;
    logic [XLEN-1:0]   ic_req_address, dc_req_address;
    memory_operation_e ic_req_type, dc_req_type;
    logic              ic_req_valid, dc_req_valid;
    logic [XLEN-1:0]   ic_word_to_store, dc_word_to_store;
    logic [XLEN-1:0]   ic_fetched_word, dc_fetched_word;
    logic              ic_req_fulfilled, dc_req_fulfilled;
    logic [XLEN-1:0]   l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [XLEN-1:0]   l2_word_to_store;
    logic [XLEN-1:0]   l2_fetched_word;
    logic              l2_req_fulfilled;

    int n_pass  = 0;
    int n_total = 0;

    l2_port_arbiter #(.XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .ic_req_address   (ic_req_address),
        .ic_req_type      (ic_req_type),
        .ic_req_valid     (ic_req_valid),
        .ic_word_to_store (ic_word_to_store),
        .ic_fetched_word  (ic_fetched_word),
        .ic_req_fulfilled (ic_req_fulfilled),
        .dc_req_address   (dc_req_address),
        .dc_req_type      (dc_req_type),
        .dc_req_valid     (dc_req_valid),
        .dc_word_to_store (dc_word_to_store),
        .dc_fetched_word  (dc_fetched_word),
        .dc_req_fulfilled (dc_req_fulfilled),
        .l2_req_address   (l2_req_address),
        .l2_req_type      (l2_req_type),
        .l2_req_valid     (l2_req_valid),
        .l2_word_to_store (l2_word_to_store),
        .l2_fetched_word  (l2_fetched_word),
        .l2_req_fulfilled (l2_req_fulfilled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // owner: 0 = none, 1 = icache, 2 = dcache (expected l2 mux source)
    typedef struct {
        bit rst;
        bit ic_v;
        bit dc_v;
        bit ful;
        bit dc_st;
        bit exp_v;
        int exp_own;
        bit exp_icf;
        bit exp_dcf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit ic_v, bit dc_v, bit ful, bit dc_st,
                                bit exp_v, int exp_own, bit exp_icf, bit exp_dcf);
        vec_t v;
        v.rst = rst; v.ic_v = ic_v; v.dc_v = dc_v; v.ful = ful; v.dc_st = dc_st;
        v.exp_v = exp_v; v.exp_own = exp_own; v.exp_icf = exp_icf; v.exp_dcf = exp_dcf;
        return v;
    endfunction

    task automatic clear_inputs();
        ic_req_valid = 0; ic_req_address = '0; ic_req_type = MEM_LOAD; ic_word_to_store = '0;
        dc_req_valid = 0; dc_req_address = '0; dc_req_type = MEM_LOAD; dc_word_to_store = '0;
        l2_req_fulfilled = 0; l2_fetched_word = '0;
    endtask

    task automatic run_table();
        logic [31:0] e_addr, e_wd, e_type, fw;
        //            rst ic dc ful st | v own icf dcf
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0)); // 0 reset
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0)); // 1 dcache load seen
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 2, 0, 0)); // 2 granted next cycle
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,  1, 2, 0, 1)); // 5 fulfil 3 cycles later
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 0)); // 7 reset
        vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0, 0, 0)); // 8 tie after reset
        vecs.push_back(mk(0, 1, 1, 0, 0,  1, 2, 0, 0)); // 9 dcache wins
        vecs.push_back(mk(0, 1, 1, 1, 0,  1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0)); // 11 bubble
        vecs.push_back(mk(0, 1, 0, 1, 0,  1, 1, 1, 0)); // 12 fulfil in first busy cycle
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0)); // 13 no regrant
        vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 0)); // 14 stray fulfil ignored
        vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 2, 0, 0)); // 16 dcache withdraws: abort
        vecs.push_back(mk(0, 1, 1, 0, 1,  0, 0, 0, 0)); // 17 tie, last served icache
        vecs.push_back(mk(0, 1, 1, 0, 1,  1, 2, 0, 0)); // 18 dcache store
        vecs.push_back(mk(0, 1, 1, 1, 1,  1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0,  1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset            = !vecs[i].rst;
            ic_req_valid     = vecs[i].ic_v;
            ic_req_address   = IC_ADDR;
            ic_req_type      = MEM_LOAD;
            ic_word_to_store = IC_WD;
            dc_req_valid     = vecs[i].dc_v;
            dc_req_address   = vecs[i].dc_st ? DC_ST_ADDR : DC_LD_ADDR;
            dc_req_type      = vecs[i].dc_st ? MEM_STORE : MEM_LOAD;
            dc_word_to_store = vecs[i].dc_st ? DC_ST_WD : DC_LD_WD;
            l2_req_fulfilled = vecs[i].ful;
            fw               = vecs[i].ful ? 32'hDEAD_BEEF : (32'h5A5A_0000 | 32'(i));
            l2_fetched_word  = fw;
            #1;
            case (vecs[i].exp_own)
                1: begin e_addr = IC_ADDR; e_wd = IC_WD; e_type = 32'(MEM_LOAD); end
                2: begin
                    e_addr = vecs[i].dc_st ? DC_ST_ADDR : DC_LD_ADDR;
                    e_wd   = vecs[i].dc_st ? DC_ST_WD : DC_LD_WD;
                    e_type = vecs[i].dc_st ? 32'(MEM_STORE) : 32'(MEM_LOAD);
                end
                default: begin e_addr = '0; e_wd = '0; e_type = '0; end
            endcase
            check($sformatf("row%0d l2_req_valid", i), 32'(l2_req_valid), 32'(vecs[i].exp_v));
            check($sformatf("row%0d l2_req_address", i), l2_req_address, e_addr);
            check($sformatf("row%0d l2_req_type", i), 32'(l2_req_type), e_type);
            check($sformatf("row%0d l2_word_to_store", i), l2_word_to_store, e_wd);
            check($sformatf("row%0d ic_req_fulfilled", i), 32'(ic_req_fulfilled), 32'(vecs[i].exp_icf));
            check($sformatf("row%0d dc_req_fulfilled", i), 32'(dc_req_fulfilled), 32'(vecs[i].exp_dcf));
            check($sformatf("row%0d ic_fetched_word", i), ic_fetched_word, fw);
            check($sformatf("row%0d dc_fetched_word", i), dc_fetched_word, fw);
        end
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        reset = 0;
        clear_inputs();
        @(negedge clk);
        reset = 1;
        ic_req_valid = 1; ic_req_address = IC_ADDR; ic_word_to_store = IC_WD;
        #1 check("rst_mid idle before grant", 32'(l2_req_valid), 32'd0);
        @(negedge clk);
        #1 check("rst_mid granted", 32'(l2_req_valid), 32'd1);
        #2 reset = 0;
        #1 check("rst_mid async drop l2_req_valid", 32'(l2_req_valid), 32'd0);
        check("rst_mid async drop l2_req_address", l2_req_address, 32'd0);
        @(negedge clk);
        reset = 1;
        #1 check("rst_mid release cycle idle", 32'(l2_req_valid), 32'd0);
        @(negedge clk);
        l2_req_fulfilled = 1;
        #1 check("rst_mid regrant valid", 32'(l2_req_valid), 32'd1);
        check("rst_mid regrant address", l2_req_address, IC_ADDR);
        check("rst_mid regrant fulfilled", 32'(ic_req_fulfilled), 32'd1);
        @(negedge clk);
        clear_inputs();
    endtask

    // Reference: at most one grant outstanding; on a tie the side served
    // least recently goes first; fulfilment or withdrawal ends the grant.
    task automatic run_traffic(input int max_cycles, input bit greedy, input int stop_after);
        int holder = -1;
        int last_served = 0;
        int served = 0;
        int grants_seen = 0;
        int last_ful_cycle = -100;
        int l2_wait = -1;
        bit prev_l2_v = 0;
        bit owner_v;
        logic [31:0] e_addr, e_wd, e_type;
        logic              n_ic_v = 0, n_dc_v = 0;
        logic [31:0]       n_ic_a = '0, n_dc_a = '0, n_ic_w = '0, n_dc_w = '0;
        memory_operation_e n_ic_t = MEM_LOAD, n_dc_t = MEM_LOAD;

        @(negedge clk);
        reset = 0;
        clear_inputs();
        @(negedge clk);
        reset = 1;
        for (int cyc = 0; cyc < max_cycles && served < stop_after; cyc++) begin
            @(negedge clk);
            ic_req_valid = n_ic_v; ic_req_address = n_ic_a; ic_req_type = n_ic_t; ic_word_to_store = n_ic_w;
            dc_req_valid = n_dc_v; dc_req_address = n_dc_a; dc_req_type = n_dc_t; dc_word_to_store = n_dc_w;
            #1;
            if (l2_req_valid) begin
                if (l2_wait < 0) l2_wait = $urandom_range(0, 3);
                l2_req_fulfilled = (l2_wait == 0);
                l2_wait = l2_req_fulfilled ? -1 : l2_wait - 1;
            end else begin
                l2_wait = -1;
                l2_req_fulfilled = ($urandom_range(0, 7) == 0);
            end
            l2_fetched_word = $urandom;
            #1;

            owner_v = (holder == 0) ? ic_req_valid : (holder == 1) ? dc_req_valid : 1'b0;
            e_addr  = (holder == 0) ? ic_req_address : (holder == 1) ? dc_req_address : '0;
            e_wd    = (holder == 0) ? ic_word_to_store : (holder == 1) ? dc_word_to_store : '0;
            e_type  = (holder == 0) ? 32'(ic_req_type) : (holder == 1) ? 32'(dc_req_type) : '0;
            check("rand l2_req_valid", 32'(l2_req_valid), 32'(owner_v));
            check("rand l2_req_address", l2_req_address, e_addr);
            check("rand l2_req_type", 32'(l2_req_type), e_type);
            check("rand l2_word_to_store", l2_word_to_store, e_wd);
            check("rand ic_req_fulfilled", 32'(ic_req_fulfilled), 32'((holder == 0) && l2_req_fulfilled));
            check("rand dc_req_fulfilled", 32'(dc_req_fulfilled), 32'((holder == 1) && l2_req_fulfilled));
            check("rand ic_fetched_word", ic_fetched_word, l2_fetched_word);
            check("rand dc_fetched_word", dc_fetched_word, l2_fetched_word);

            if (greedy && l2_req_valid && !prev_l2_v) begin
                // dcache addresses carry bit 31; expected order D,I,D,I,...
                check($sformatf("greedy grant %0d is dcache", grants_seen),
                      32'(l2_req_address[31]), 32'(grants_seen % 2 == 0));
                if (grants_seen > 0)
                    check($sformatf("greedy grant %0d gap", grants_seen), 32'(cyc - last_ful_cycle), 32'd2);
                grants_seen++;
            end
            prev_l2_v = l2_req_valid;

            if (holder >= 0) begin
                if (l2_req_fulfilled) begin
                    last_served = holder;
                    holder = -1;
                    served++;
                    last_ful_cycle = cyc;
                end else if (!owner_v) begin
                    holder = -1;
                end
            end else if (ic_req_valid && dc_req_valid) begin
                holder = (last_served == 0) ? 1 : 0;
            end else if (ic_req_valid) begin
                holder = 0;
            end else if (dc_req_valid) begin
                holder = 1;
            end

            if (ic_req_valid) n_ic_v = !ic_req_fulfilled;
            else if (greedy || $urandom_range(0, 2) == 0) begin
                n_ic_v = 1;
                n_ic_a = $urandom & 32'h7FFF_FFFC;
                n_ic_t = memory_operation_e'($urandom_range(0, 3));
                n_ic_w = $urandom;
            end else n_ic_v = 0;
            if (dc_req_valid) n_dc_v = !dc_req_fulfilled;
            else if (greedy || $urandom_range(0, 2) == 0) begin
                n_dc_v = 1;
                n_dc_a = $urandom | 32'h8000_0000;
                n_dc_t = memory_operation_e'($urandom_range(0, 3));
                n_dc_w = $urandom;
            end else n_dc_v = 0;
        end
        if (stop_after < max_cycles)
            check("traffic transactions completed in budget", 32'(served >= stop_after), 32'd1);
        if (greedy)
            check("greedy grants observed", 32'(grants_seen), 32'(stop_after));
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        reset = 0;
        clear_inputs();
        run_table();
        reset_mid_busy();
        run_traffic(200, 1'b1, 6);
        run_traffic(3000, 1'b0, 100000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
